axi_read_arbiter_rr: RTL

- Parametrised N-master read-address arbiter for the AXI bridge read path.
- Selects one pending AR request using round-robin or fixed priority and registers the grant.
- Presents the registered AR request to the decoder and returns ARREADY only to the granted master.
- Holds the read-address/read-data mux selects until the decoder reports `finish`; a watchdog recovers from a missing `finish`.

---
 rtl/axi_arb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 34 +++
 rtl/axi_read_arbiter_rr.sv | 130 +++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the AXI read-address arbiter.
// Default widths track the bridge-wide AXI_define settings.
package axi_arb_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_ID_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin scan from ptr, or lowest index first.
module rr_picker
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_W       = clog2_min1(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [SEL_W-1:0]       ptr,
  input  logic                   rr_mode,
  output logic [SEL_W-1:0]       winner,
  output logic                   any_req
);

  logic        found;
  int unsigned idx;

  // Offset k walks the candidates in priority order; the first requester wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = rr_mode ? (32'(ptr) + k) % NUM_MASTERS : k;
      if (!found && req[SEL_W'(idx)]) begin
        winner = SEL_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_read_arbiter_rr.sv
// N-master AR arbiter: registers one grant, forwards the latched AR request and
// holds the AR/R mux selects until the decoder reports finish or the watchdog fires.
module axi_read_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = AXI_ADDR_W,
  parameter int unsigned ID_W        = AXI_ID_W,
  parameter int unsigned RR_MODE     = 1,
  parameter int unsigned TIMEOUT     = 1024,
  localparam int unsigned SEL_W      = clog2_min1(NUM_MASTERS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        ARVALID_M,
  input  logic [NUM_MASTERS*ADDR_W-1:0] ARADDR_M,
  output logic [NUM_MASTERS-1:0]        ARREADY_M,
  output logic                          ARVALID,
  output logic [ADDR_W-1:0]             ARADDR,
  output logic [ID_W-1:0]               MasterID,
  input  logic                          ARREADY,
  input  logic                          finish,
  output logic                          grant_valid,
  output logic [SEL_W-1:0]              ReadAddressSel,
  output logic [SEL_W-1:0]              ReadDataSel,
  output logic                          timeout_pulse
);

  localparam int unsigned WD_W = clog2_min1(TIMEOUT);

  arb_state_t        state, state_n;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  grant_q;
  logic [SEL_W-1:0]  pick;
  logic              any_req;
  logic [ADDR_W-1:0] pick_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              timeout_q;
  logic              load_grant;
  logic              release_grant;
  logic              wd_fire;

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .SEL_W       (SEL_W)
  ) u_picker (
    .req     (ARVALID_M),
    .ptr     (rr_ptr),
    .rr_mode (RR_MODE != 0),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    pick_addr = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (pick == SEL_W'(i)) pick_addr = ARADDR_M[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // ARREADY wins over a simultaneous finish because finish is only looked at in DATA.
  always_comb begin
    state_n       = state;
    load_grant    = 1'b0;
    release_grant = 1'b0;
    wd_fire       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n    = ADDR;
          load_grant = 1'b1;
        end
      end
      ADDR: begin
        if (ARREADY) state_n = DATA;
      end
      DATA: begin
        if (finish) begin
          state_n       = IDLE;
          release_grant = 1'b1;
        end else if (TIMEOUT != 0 && wd_cnt == WD_W'(TIMEOUT - 1)) begin
          state_n       = IDLE;
          release_grant = 1'b1;
          wd_fire       = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if (load_grant) begin
        grant_q <= pick;
        addr_q  <= pick_addr;
      end
      if (release_grant) begin
        rr_ptr <= (grant_q == SEL_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
      end
      wd_cnt <= (state == DATA && state_n == DATA) ? wd_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    ARREADY_M = '0;
    if (state == ADDR) ARREADY_M[grant_q] = ARREADY;
  end

  assign ARVALID        = (state == ADDR);
  assign ARADDR         = addr_q;
  assign MasterID       = ID_W'(grant_q);
  assign grant_valid    = (state != IDLE);
  assign ReadAddressSel = grant_q;
  assign ReadDataSel    = grant_q;
  assign timeout_pulse  = timeout_q;

endmodule
